// File: rtl/lif_neuron_pipe.sv
// lif_neuron_pipe: two-stage pipelined leaky integrate-and-fire update engine.
//
// The engine is time-multiplexed across NEUR_N neurons whose state lives in an
// external SRAM. Stage 1 decodes the event and registers the arithmetic result.
// Stage 2 applies the threshold and refractory logic and drives the write-back
// and spike outputs.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high. A producer holds valid and its payload steady until the transfer.
// ready may depend combinationally on the payload (in_ready looks at in_neur_idx).
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   in_valid / in_ready   update request handshake
//   in_neur_idx           neuron index
//   in_state, in_refr     membrane state and refractory count read from SRAM
//   in_syn_weight         signed synaptic weight
//   in_syn_event          event trigger
//   in_time_ref           with in_syn_event: leak/time-step event, not a synaptic event
//   param_leak_str        leak magnitude, sampled when stage 1 loads
//   param_thr             firing threshold, sampled when stage 2 loads
//   param_refr_per        refractory period loaded on a spike, sampled when stage 2 loads
//   out_valid / out_ready result handshake
//   out_neur_idx, out_state, out_refr, out_spike   write-back result
//
// Optional feature (macro LIF_SPIKE_CNT_EN): adds cnt_clr (in) and spike_cnt
// (out, 16 bits), a saturating count of spikes delivered downstream.
module lif_neuron_pipe #(
    parameter int STATE_W  = 12,
    parameter int WEIGHT_W = 4,
    parameter int LEAK_W   = 7,
    parameter int REFR_W   = 4,
    parameter int NEUR_N   = 256,
    localparam int IDX_W   = $clog2(NEUR_N)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDX_W-1:0]    in_neur_idx,
    input  logic [STATE_W-1:0]  in_state,
    input  logic [REFR_W-1:0]   in_refr,
    input  logic [WEIGHT_W-1:0] in_syn_weight,
    input  logic                in_syn_event,
    input  logic                in_time_ref,
    input  logic [LEAK_W-1:0]   param_leak_str,
    input  logic [STATE_W-1:0]  param_thr,
    input  logic [REFR_W-1:0]   param_refr_per,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_neur_idx,
    output logic [STATE_W-1:0]  out_state,
    output logic [REFR_W-1:0]   out_refr,
    output logic                out_spike
`ifdef LIF_SPIKE_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [15:0]         spike_cnt
`endif
);

    localparam int MSB = STATE_W - 1;

    // Stage 1 registers
    logic               s1_valid_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [STATE_W-1:0] s1_state_q;
    logic [REFR_W-1:0]  s1_refr_q;

    // Stage 2 registers (these drive the outputs directly)
    logic               s2_valid_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [STATE_W-1:0] out_state_q;
    logic [REFR_W-1:0]  out_refr_q;
    logic               out_spike_q;

    logic s1_advance, s1_load, hazard, in_fire, fwd, spike_d;
    logic [STATE_W-1:0] st_in, s1_state_d;
    logic [REFR_W-1:0]  refr_in, s1_refr_d;
    logic [STATE_W:0]   st_ext, w_ext, leak_ext, sum;

    // Stage 2 loads whenever it is empty or its result leaves this cycle;
    // stage 1 advances into it under the same condition.
    assign s1_advance = ~s2_valid_q | out_ready;
    assign s1_load    = ~s1_valid_q | s1_advance;

    // A request for the neuron still in stage 1 must wait one cycle: its
    // up-to-date value is not known until stage 2 has applied the threshold.
    assign hazard   = s1_valid_q & (in_neur_idx == s1_idx_q);
    assign in_ready = s1_load & ~hazard;
    assign in_fire  = in_valid & in_ready;

    // The stage 2 result is what will be written back, so it supersedes the
    // stale SRAM read for the same neuron.
    assign fwd     = s2_valid_q & (in_neur_idx == out_idx_q);
    assign st_in   = fwd ? out_state_q : in_state;
    assign refr_in = fwd ? out_refr_q  : in_refr;

    // Event decode and arithmetic, done one bit wider to detect overflow.
    always_comb begin
        s1_state_d = st_in;
        s1_refr_d  = refr_in;
        st_ext     = {st_in[MSB], st_in};
        w_ext      = {{(STATE_W + 1 - WEIGHT_W){in_syn_weight[WEIGHT_W-1]}}, in_syn_weight};
        leak_ext   = {{(STATE_W + 1 - LEAK_W){1'b0}}, param_leak_str};
        sum        = '0;
        if (in_syn_event && in_time_ref) begin
            // Leak moves the state toward zero and never crosses it.
            if (!st_in[MSB]) begin
                sum        = st_ext - leak_ext;
                s1_state_d = sum[STATE_W] ? '0 : sum[STATE_W-1:0];
            end else begin
                sum        = st_ext + leak_ext;
                s1_state_d = sum[STATE_W] ? sum[STATE_W-1:0] : '0;
            end
            if (refr_in != '0) begin
                s1_refr_d = refr_in - {{(REFR_W - 1){1'b0}}, 1'b1};
            end
        end else if (in_syn_event && (refr_in == '0)) begin
            // Synaptic input saturates; events during refractory are absorbed.
            sum = st_ext + w_ext;
            if (sum[STATE_W] != sum[STATE_W-1]) begin
                s1_state_d = sum[STATE_W] ? {1'b1, {(STATE_W - 1){1'b0}}}
                                          : {1'b0, {(STATE_W - 1){1'b1}}};
            end else begin
                s1_state_d = sum[STATE_W-1:0];
            end
        end
    end

    // Threshold is positive, so an unsigned compare against a non-negative
    // state is exact.
    assign spike_d = ~s1_state_q[MSB] & (s1_state_q >= param_thr);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_state_q <= '0;
            s1_refr_q  <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_idx_q   <= in_neur_idx;
                s1_state_q <= s1_state_d;
                s1_refr_q  <= s1_refr_d;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid_q  <= 1'b0;
            out_idx_q   <= '0;
            out_state_q <= '0;
            out_refr_q  <= '0;
            out_spike_q <= 1'b0;
        end else if (s1_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_idx_q   <= s1_idx_q;
                out_spike_q <= spike_d;
                out_state_q <= spike_d ? '0 : s1_state_q;
                out_refr_q  <= spike_d ? param_refr_per : s1_refr_q;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_neur_idx = out_idx_q;
    assign out_state    = out_state_q;
    assign out_refr     = out_refr_q;
    assign out_spike    = out_spike_q;

`ifdef LIF_SPIKE_CNT_EN
    logic [15:0] spike_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            spike_cnt_q <= '0;
        end else if (cnt_clr) begin
            spike_cnt_q <= '0;
        end else if (s2_valid_q && out_ready && out_spike_q && (spike_cnt_q != 16'hFFFF)) begin
            spike_cnt_q <= spike_cnt_q + 16'd1;
        end
    end

    assign spike_cnt = spike_cnt_q;
`endif

endmodule

// File: tb/tb_lif_neuron_pipe.sv
// Directed bench for lif_neuron_pipe with a scoreboard queue and an output monitor.
module tb_lif_neuron_pipe;

    localparam int IW = 8;
    localparam int SW = 12;
    localparam int WW = 4;
    localparam int LW = 7;
    localparam int RW = 4;
    localparam int EW = IW + SW + RW + 1;

    logic          CLK, RST;
    logic          in_valid, in_ready;
    logic [IW-1:0] in_neur_idx;
    logic [SW-1:0] in_state;
    logic [RW-1:0] in_refr;
    logic [WW-1:0] in_syn_weight;
    logic          in_syn_event, in_time_ref;
    logic [LW-1:0] param_leak_str;
    logic [SW-1:0] param_thr;
    logic [RW-1:0] param_refr_per;
    logic          out_valid, out_ready;
    logic [IW-1:0] out_neur_idx;
    logic [SW-1:0] out_state;
    logic [RW-1:0] out_refr;
    logic          out_spike;
`ifdef LIF_SPIKE_CNT_EN
    logic          cnt_clr;
    logic [15:0]   spike_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    lif_neuron_pipe dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_neur_idx(in_neur_idx),
        .in_state(in_state), .in_refr(in_refr), .in_syn_weight(in_syn_weight),
        .in_syn_event(in_syn_event), .in_time_ref(in_time_ref),
        .param_leak_str(param_leak_str), .param_thr(param_thr), .param_refr_per(param_refr_per),
        .out_valid(out_valid), .out_ready(out_ready), .out_neur_idx(out_neur_idx),
        .out_state(out_state), .out_refr(out_refr), .out_spike(out_spike)
`ifdef LIF_SPIKE_CNT_EN
        , .cnt_clr(cnt_clr), .spike_cnt(spike_cnt)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] mk(input int idx, input int st, input int rf, input bit sp);
        return {idx[IW-1:0], st[SW-1:0], rf[RW-1:0], sp};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // scoreboard monitor: a transfer happens at the posedge following a negedge
    // where out_valid & out_ready.
    always @(negedge CLK) begin
        logic [EW-1:0] got, e;
        if (!RST && out_valid && out_ready) begin
            got = {out_neur_idx, out_state, out_refr, out_spike};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got idx=%0d st=%0h rf=%0d sp=%0b exp=none",
                         out_neur_idx, out_state, out_refr, out_spike);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL result: got idx=%0d st=%0h rf=%0d sp=%0b exp idx=%0d st=%0h rf=%0d sp=%0b",
                             got[EW-1 -: IW], got[SW+RW:RW+1], got[RW:1], got[0],
                             e[EW-1 -: IW], e[SW+RW:RW+1], e[RW:1], e[0]);
                end
            end
        end
    end

    // driver: present one request, wait (bounded) for acceptance
    task automatic send(input int idx, input int st, input int rf, input int w, input bit tr,
                        input logic [EW-1:0] e, input bit push, output int stalls);
        in_neur_idx   = idx[IW-1:0];
        in_state      = st[SW-1:0];
        in_refr       = rf[RW-1:0];
        in_syn_weight = w[WW-1:0];
        in_syn_event  = 1'b1;
        in_time_ref   = tr;
        in_valid      = 1'b1;
        if (push) exp_q.push_back(e);
        stalls = 0;
        forever begin
            @(negedge CLK);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout: got=no_ready exp=ready idx=%0d", idx);
                break;
            end
        end
        @(posedge CLK);
        #1;
        in_valid     = 1'b0;
        in_syn_event = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got=%0d_pending exp=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic stall_outputs();
        int n = 0;
        logic [EW-1:0] snap;
        while (!out_valid && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("stall_seen_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        @(negedge CLK);
        snap = {out_neur_idx, out_state, out_refr, out_spike};
        repeat (3) begin
            @(negedge CLK);
            chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            chk("stall_out_stable", 32'({out_neur_idx, out_state, out_refr, out_spike}), 32'(snap));
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        int s, n;
        RST = 1'b1;
        in_valid = 0; in_neur_idx = 0; in_state = 0; in_refr = 0; in_syn_weight = 0;
        in_syn_event = 0; in_time_ref = 0;
        param_leak_str = 7'd2; param_thr = 12'd10; param_refr_per = 4'd3;
        out_ready = 1'b1;
`ifdef LIF_SPIKE_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_spike", {31'd0, out_spike}, 32'd0);
        chk("rst_out_state", {20'd0, out_state}, 32'd0);
        chk("rst_out_refr",  {28'd0, out_refr}, 32'd0);
        chk("rst_out_idx",   {24'd0, out_neur_idx}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
`ifdef LIF_SPIKE_CNT_EN
        chk("rst_spike_cnt", {16'd0, spike_cnt}, 32'd0);
`endif
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // fire: 8 + 3 = 11 >= 10, two-cycle latency
        send(5, 8, 0, 3, 0, mk(5, 0, 3, 1), 1, s);
        @(negedge CLK);
        chk("latency_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge CLK);
        chk("latency_cycle2", {31'd0, out_valid}, 32'd1);
        drain();

        // refractory absorbs a synaptic event, then a leak event counts it down
        send(5, 0, 3, 7, 0, mk(5, 0, 3, 0), 1, s);
        send(5, 0, 3, 0, 1, mk(5, 0, 2, 0), 1, s);
        drain();

        // saturation at both rails
        param_thr = 12'd2047;
        send(1, 2040, 0, 7, 0, mk(1, 0, 3, 1), 1, s);
        send(2, -2045, 0, -8, 0, mk(2, -2048, 0, 0), 1, s);
        drain();
        param_thr = 12'd10;

        // leak toward zero never crosses it; zero leak is a no-op
        param_leak_str = 7'd5;
        send(3, 3, 0, 0, 1, mk(3, 0, 0, 0), 1, s);
        send(4, -3, 0, 0, 1, mk(4, 0, 0, 0), 1, s);
        send(6, -20, 0, 0, 1, mk(6, -15, 0, 0), 1, s);
        drain();
        param_leak_str = 7'd0;
        send(8, 9, 0, 0, 1, mk(8, 9, 0, 0), 1, s);
        drain();
        param_leak_str = 7'd2;

        // back-to-back same neuron: one stall cycle per hazard, forwarding 1,2,3
        send(7, 0, 0, 1, 0, mk(7, 1, 0, 0), 1, s);
        chk("hazard_stalls_first", 32'(s), 32'd0);
        send(7, 0, 0, 1, 0, mk(7, 2, 0, 0), 1, s);
        chk("hazard_stalls_second", 32'(s), 32'd1);
        send(7, 0, 0, 1, 0, mk(7, 3, 0, 0), 1, s);
        chk("hazard_stalls_third", 32'(s), 32'd1);
        drain();

        // downstream stall mid-stream: outputs held, nothing lost
        fork
            begin
                int s2;
                send(9, 2, 0, 1, 0, mk(9, 3, 0, 0), 1, s2);
                send(10, -5, 0, 2, 0, mk(10, -3, 0, 0), 1, s2);
                send(11, 9, 0, 1, 0, mk(11, 0, 3, 1), 1, s2);
            end
            stall_outputs();
        join
        drain();

`ifdef LIF_SPIKE_CNT_EN
        // spike counter: three spikes, then clear concurrent with a fourth
        send(20, 8, 0, 3, 0, mk(20, 0, 3, 1), 1, s);
        send(21, 8, 0, 3, 0, mk(21, 0, 3, 1), 1, s);
        send(22, 8, 0, 3, 0, mk(22, 0, 3, 1), 1, s);
        drain();
        chk("spike_cnt_three", {16'd0, spike_cnt}, 32'd3);
        send(23, 8, 0, 3, 0, mk(23, 0, 3, 1), 1, s);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!out_valid && n < 20);
        cnt_clr = 1'b1;
        @(posedge CLK);
        #1;
        cnt_clr = 1'b0;
        chk("spike_cnt_clr_wins", {16'd0, spike_cnt}, 32'd0);
        drain();
        send(24, 8, 0, 3, 0, mk(24, 0, 3, 1), 1, s);
        drain();
        chk("spike_cnt_one", {16'd0, spike_cnt}, 32'd1);
`endif

        // reset while a result is stalled: flushed immediately
        out_ready = 1'b0;
        send(12, 9, 0, 3, 0, '0, 0, s);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        RST = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_state", {20'd0, out_state}, 32'd0);
        chk("midrst_out_spike", {31'd0, out_spike}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
`ifdef LIF_SPIKE_CNT_EN
        chk("midrst_spike_cnt", {16'd0, spike_cnt}, 32'd0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("post_reset_idle", {31'd0, out_valid}, 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_neuron_pipe.md
Name: lif_neuron_pipe

Overview:
Parametrised, two-stage pipelined leaky integrate-and-fire neuron update engine, successor to the 12-bit combinational LIF charge logic.
- Time-multiplexed across NEUR_N neurons stored in external SRAM.
- Adds configurable state/weight widths, a refractory-period counter, a valid/ready handshake on both sides, and read-after-write hazard handling.
- Sits between the controller's neuron-state read port and the state write-back/spike-output path.

Parameters:
STATE_W, 12, signed two's-complement membrane state width (min 8)
WEIGHT_W, 4, signed synaptic weight width (< STATE_W)
LEAK_W, 7, unsigned leak strength width (< STATE_W)
REFR_W, 4, refractory counter width
NEUR_N, 256, neuron count; IDX_W = $clog2(NEUR_N)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
in_valid  in  1  update request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_neur_idx  in  IDX_W  neuron index
in_state  in  STATE_W  membrane state read from SRAM
in_refr  in  REFR_W  refractory count read from SRAM
in_syn_weight  in  WEIGHT_W  signed synaptic weight
in_syn_event  in  1  event trigger
in_time_ref  in  1  with in_syn_event: leak/time-step event instead of synaptic event
param_leak_str  in  LEAK_W  leak magnitude
param_thr  in  STATE_W  firing threshold, positive
param_refr_per  in  REFR_W  refractory period loaded on spike
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_neur_idx  out  IDX_W  neuron index of result
out_state  out  STATE_W  next membrane state for write-back
out_refr  out  REFR_W  next refractory count for write-back
out_spike  out  1  neuron fired

Behaviour:
- Reset (async, RST=1): s1_valid=0, s2_valid=0; out_valid=0, out_spike=0, out_state=0, out_refr=0, out_neur_idx=0. in_ready=1 after reset.
- Pipeline:
  - S1 registers the arithmetic result; S2 registers the threshold/refractory result.
  - Latency: 2 cycles from input handshake to out_valid.
  - Throughput: 1 update per cycle when unstalled.
- Stall: S2 holds while out_valid & ~out_ready. S1 advances iff ~s2_valid | (out_valid & out_ready). in_ready = (~s1_valid | s1_advance) & ~hazard.
- Outputs stay stable while out_valid & ~out_ready.
- Hazard: hazard = s1_valid & (in_neur_idx == s1_idx). While hazard is set, in_ready=0.
- Forwarding: if s2_valid & (in_neur_idx == s2_idx), S1 uses out_state/out_refr instead of in_state/in_refr. The forwarded values are the values that will be written back to SRAM.
- S1 event decode, with refr_in = forwarded or in_refr:
  - leak event (syn_event & time_ref):
    - state >= 0: state - leak, floored at 0.
    - state < 0: state + leak, capped at 0.
    - refr_in > 0: decrement refr by 1.
  - syn event (syn_event & ~time_ref):
    - refr_in == 0: state + sign-extended weight, saturating to [-2^(STATE_W-1), 2^(STATE_W-1)-1].
    - refr_in > 0: state and refr unchanged (event absorbed).
  - no event: pass-through.
- S2 fire: spike = ~s1_state[MSB] & (s1_state >= param_thr).
  - On spike: out_state=0, out_refr=param_refr_per.
  - Otherwise: values pass through.
  - param_thr is compared unsigned against the non-negative state.
- Leak never crosses zero. With leak=0 the state is unchanged.
- Parameters are sampled at S1 (param_leak_str) and at S2 (param_thr, param_refr_per) in the cycle each stage loads.
- RST mid-operation flushes both stages; in-flight results are lost. The controller re-issues them.

Optional Feature:
- Macro: LIF_SPIKE_CNT_EN.
- Defined: adds ports cnt_clr (in, 1) and spike_cnt (out, 16).
  - spike_cnt increments on each out_valid & out_ready & out_spike and saturates at 16'hFFFF.
  - cnt_clr zeroes it synchronously; clear wins over a simultaneous increment.
  - RST clears it to 0.
- Undefined: neither port nor the counter exists. Datapath behaviour is identical.

Test Plan:
- Defaults, thr=10, refr_per=3: idx 5 state=8, syn weight=+3 -> 2 cycles later out_valid, out_spike=1, out_state=0, out_refr=3.
- idx 5 state=0, refr=3, syn weight=+7 -> out_state=0, out_refr=3, no spike. Then leak event, leak=2 -> out_refr=2, state 0.
- Saturation: state=2040, weight=+7 with thr=2047 -> out_state=2047, spike=1, out_state written 0. State=-2045, weight=-8 -> out_state=-2048.
- Leak toward zero: state=3, leak=5 -> 0. State=-3, leak=5 -> 0. State=-20, leak=5 -> -15.
- Back-to-back idx 7, 7, 7, each weight +1 from SRAM state 0 (SRAM not yet updated):
  - in_ready drops one cycle per hazard.
  - Forwarding yields results 1, 2, 3.
  - out_ready held 0 for 4 cycles mid-stream -> outputs stable, no loss.
- Macro defined: 3 spikes accepted -> spike_cnt=3. cnt_clr concurrent with 4th spike -> spike_cnt=0. RST asserted mid-stall -> out_valid=0 and spike_cnt=0 the same cycle.
